// File: rtl/seq_div_axis.sv
// rtl/seq_div_axis.sv - signed restoring divider with AXI-Stream style operand/result handshakes
// Optional macro SEQ_DIV_DIVBYZERO_EN adds m_axis_dout_tuser and saturating divide-by-zero results.
module seq_div_axis #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_axis_dividend_tvalid,
  input  logic [DATA_WIDTH-1:0]   s_axis_dividend_tdata,
  output logic                    s_axis_dividend_tready,
  input  logic                    s_axis_divisor_tvalid,
  input  logic [DATA_WIDTH-1:0]   s_axis_divisor_tdata,
  output logic                    s_axis_divisor_tready,
  output logic                    m_axis_dout_tvalid,
  output logic [2*DATA_WIDTH-1:0] m_axis_dout_tdata,
`ifdef SEQ_DIV_DIVBYZERO_EN
  output logic                    m_axis_dout_tuser,
`endif
  input  logic                    m_axis_dout_tready
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, DIVIDE, SIGN, OUT} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W:0]        rem_q, rem_d;
  logic [W-1:0]      quo_q, quo_d;
  logic [W-1:0]      dvs_q, dvs_d;
  logic              neg_dvd_q, neg_dvd_d;
  logic              neg_dvs_q, neg_dvs_d;
  logic              tvalid_q, tvalid_d;
  logic [2*W-1:0]    tdata_q, tdata_d;
`ifdef SEQ_DIV_DIVBYZERO_EN
  logic              dz_q, dz_d;
  logic              tuser_q, tuser_d;
`endif

  logic              accept;
  logic [W+1:0]      trial;
  logic [W+1:0]      diff;
  logic [W-1:0]      q_res;
  logic [W-1:0]      r_res;

  // The quotient register starts out holding the dividend magnitude; its MSB
  // is shifted into the partial remainder as each quotient bit is shifted in.
  assign trial = {rem_q, quo_q[W-1]};
  assign diff  = trial - {2'b00, dvs_q};

  assign accept = (state_q == IDLE) && s_axis_dividend_tvalid && s_axis_divisor_tvalid;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_dvd_d = neg_dvd_q;
    neg_dvs_d = neg_dvs_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    q_res     = quo_q;
    r_res     = rem_q[W-1:0];
`ifdef SEQ_DIV_DIVBYZERO_EN
    dz_d      = dz_q;
    tuser_d   = tuser_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          neg_dvd_d = s_axis_dividend_tdata[W-1];
          neg_dvs_d = s_axis_divisor_tdata[W-1];
          quo_d     = s_axis_dividend_tdata[W-1] ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
          dvs_d     = s_axis_divisor_tdata[W-1] ? -s_axis_divisor_tdata : s_axis_divisor_tdata;
          rem_d     = '0;
          cnt_d     = CW'(W - 1);
`ifdef SEQ_DIV_DIVBYZERO_EN
          dz_d      = (s_axis_divisor_tdata == '0);
`endif
          state_d   = DIVIDE;
        end
      end
      DIVIDE: begin
        if (!diff[W+1]) begin
          rem_d = diff[W:0];
          quo_d = {quo_q[W-2:0], 1'b1};
        end else begin
          rem_d = trial[W:0];
          quo_d = {quo_q[W-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = SIGN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      SIGN: begin
        // A zero divisor yields an all-ones magnitude quotient, which the sign
        // fix-up turns into 0xFFFF / 0x0001 without any special casing.
        q_res = (neg_dvd_q ^ neg_dvs_q) ? -quo_q : quo_q;
        r_res = neg_dvd_q ? -rem_q[W-1:0] : rem_q[W-1:0];
`ifdef SEQ_DIV_DIVBYZERO_EN
        if (dz_q) q_res = neg_dvd_q ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        tuser_d = dz_q;
`endif
        tdata_d = {r_res, q_res};
        state_d = OUT;
      end
      OUT: begin
        if (tvalid_q && m_axis_dout_tready) begin
          tvalid_d = 1'b0;
          state_d  = IDLE;
        end else begin
          tvalid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_dvd_q <= 1'b0;
      neg_dvs_q <= 1'b0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
`ifdef SEQ_DIV_DIVBYZERO_EN
      dz_q      <= 1'b0;
      tuser_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_dvd_q <= neg_dvd_d;
      neg_dvs_q <= neg_dvs_d;
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
`ifdef SEQ_DIV_DIVBYZERO_EN
      dz_q      <= dz_d;
      tuser_q   <= tuser_d;
`endif
    end
  end

  assign s_axis_dividend_tready = (state_q == IDLE) && !rst;
  assign s_axis_divisor_tready  = s_axis_dividend_tready;
  assign m_axis_dout_tvalid     = tvalid_q;
  assign m_axis_dout_tdata      = tdata_q;
`ifdef SEQ_DIV_DIVBYZERO_EN
  assign m_axis_dout_tuser      = tuser_q;
`endif

endmodule
